// File: rtl/grid_frame_scheduler.sv
// grid_frame_scheduler: frame sequencer and frame-buffer write arbiter.
// Optional write-out watchdog enabled by defining SCHED_TIMEOUT_EN.
module grid_frame_scheduler #(
  parameter int NUM_ITER   = 16,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int WR_TIMEOUT = 1023
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              enable,
  output logic              comp_step,
  input  logic              comp_done,
  output logic              comp_allow,
  input  logic              done_write_sig,
  input  logic              gw_we,
  input  logic [ADDR_W-1:0] gw_addr,
  input  logic [DATA_W-1:0] gw_data,
  input  logic              ov_req,
  input  logic [ADDR_W-1:0] ov_addr,
  input  logic [DATA_W-1:0] ov_data,
  output logic              ov_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [15:0]       frame_count,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_WAIT,
    S_WRITE,
    S_FEND
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [7:0]          r_iter;
  logic                r_comp_step;
  logic                r_comp_allow;
  logic [15:0]         r_frame_cnt;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_data;
  logic                w_last;
  logic                w_done_last;
  logic                w_wr_end;
  logic                w_gw_sel;
  logic                w_busy;
  logic                w_ov_gnt;

  assign w_last      = (r_iter == 8'(NUM_ITER - 1));
  assign w_done_last = (r_state == S_WAIT) && comp_done && w_last;

`ifdef SCHED_TIMEOUT_EN
  localparam int WD_W = (WR_TIMEOUT > 1) ? $clog2(WR_TIMEOUT) : 1;

  logic [WD_W-1:0] r_wdog;
  logic            r_timeout_err;
  logic            w_wd_hit;

  // limit hit on the WR_TIMEOUT-th cycle spent in WRITE
  assign w_wd_hit = (r_state == S_WRITE) &&
                    (r_wdog == WD_W'(WR_TIMEOUT - 1));

  // watchdog: counts WRITE cycles, cleared outside WRITE
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      r_wdog <= '0;
    end else if (r_state == S_WRITE) begin
      r_wdog <= r_wdog + 1'b1;
    end else begin
      r_wdog <= '0;
    end
  end

  // sticky error; a same-cycle done is a normal completion
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      r_timeout_err <= 1'b0;
    end else if (w_wd_hit && !done_write_sig) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign w_wr_end    = done_write_sig | w_wd_hit;
  assign timeout_err = r_timeout_err;
`else
  assign w_wr_end    = done_write_sig;
  assign timeout_err = 1'b0;
`endif

  // state register
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (enable) w_next = S_STEP;
      S_STEP:  w_next = S_WAIT;
      S_WAIT: begin
        if (comp_done) begin
          w_next = w_last ? S_WRITE : S_STEP;
        end
      end
      S_WRITE: if (w_wr_end) w_next = S_FEND;
      S_FEND:  w_next = enable ? S_STEP : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // output decode: busy flag and write-port arbitration
  always_comb begin
    w_busy   = (r_state != S_IDLE);
    w_gw_sel = (r_state == S_WRITE) && gw_we;
    w_ov_gnt = ov_req && !w_gw_sel;
  end

  // iteration counter, cleared at frame start and on last iteration
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      r_iter <= '0;
    end else if ((r_state == S_IDLE) && enable) begin
      r_iter <= '0;
    end else if ((r_state == S_WAIT) && comp_done) begin
      r_iter <= w_last ? 8'd0 : r_iter + 8'd1;
    end
  end

  // step pulse: issued from IDLE directly, else once per STEP visit
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      r_comp_step <= 1'b0;
    end else begin
      r_comp_step <= ((r_state == S_IDLE) && enable) ||
                     ((r_state == S_STEP) && !r_comp_step);
    end
  end

  // compute/write phase gate for the grid writer
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      r_comp_allow <= 1'b1;
    end else if (w_done_last) begin
      r_comp_allow <= 1'b0;
    end else if (r_state == S_FEND) begin
      r_comp_allow <= 1'b1;
    end
  end

  // completed-frame counter, wraps silently
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      r_frame_cnt <= '0;
    end else if (r_state == S_FEND) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // registered write port: grid writer first, then overlay
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else if (w_gw_sel) begin
      r_mem_we   <= 1'b1;
      r_mem_addr <= gw_addr;
      r_mem_data <= gw_data;
    end else if (ov_req) begin
      r_mem_we   <= 1'b1;
      r_mem_addr <= ov_addr;
      r_mem_data <= ov_data;
    end else begin
      r_mem_we   <= 1'b0;
    end
  end

  assign comp_step   = r_comp_step;
  assign comp_allow  = r_comp_allow;
  assign frame_count = r_frame_cnt;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_data    = r_mem_data;
  assign busy        = w_busy;
  assign ov_gnt      = w_ov_gnt;

endmodule

// File: tb/tb_grid_frame_scheduler.sv
// tb_grid_frame_scheduler: directed self-checking bench.
// Timeout expectations follow SCHED_TIMEOUT_EN.
module tb_grid_frame_scheduler;

  localparam int NI = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int WT = 20;

  logic          clk_50 = 1'b0;
  logic          reset;
  logic          enable;
  logic          comp_step;
  logic          comp_done;
  logic          comp_allow;
  logic          done_write_sig;
  logic          gw_we;
  logic [AW-1:0] gw_addr;
  logic [DW-1:0] gw_data;
  logic          ov_req;
  logic [AW-1:0] ov_addr;
  logic [DW-1:0] ov_data;
  logic          ov_gnt;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [15:0]   frame_count;
  logic          busy;
  logic          timeout_err;

  int n_assert = 0;
  int n_fail   = 0;
  int step_cnt = 0;
  int we_cnt   = 0;

  grid_frame_scheduler #(
    .NUM_ITER   (NI),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .WR_TIMEOUT (WT)
  ) dut (
    .clk_50         (clk_50),
    .reset          (reset),
    .enable         (enable),
    .comp_step      (comp_step),
    .comp_done      (comp_done),
    .comp_allow     (comp_allow),
    .done_write_sig (done_write_sig),
    .gw_we          (gw_we),
    .gw_addr        (gw_addr),
    .gw_data        (gw_data),
    .ov_req         (ov_req),
    .ov_addr        (ov_addr),
    .ov_data        (ov_data),
    .ov_gnt         (ov_gnt),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .frame_count    (frame_count),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #10 clk_50 = ~clk_50;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50);
    #1;
    if (comp_step) step_cnt++;
    if (mem_we) we_cnt++;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_allow"}, comp_allow, 1);
    chk({tag, "_step"}, comp_step, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_data"}, mem_data, 0);
    chk({tag, "_frame"}, frame_count, 0);
    chk({tag, "_terr"}, timeout_err, 0);
  endtask

  // entered on a comp_step cycle; done returned 3 cycles later
  task automatic do_iters(input bit drop);
    for (int k = 0; k < NI; k++) begin
      if (drop && k == 1) enable = 1'b0;
      tick();
      tick();
      tick();
      comp_done = 1'b1;
      tick();
      comp_done = 1'b0;
      if (k < NI - 1) begin
        chk("step_gap", comp_step, 0);
        chk("allow_comp", comp_allow, 1);
        tick();
        chk("step_turn", comp_step, 1);
      end else begin
        chk("allow_low", comp_allow, 0);
      end
    end
  endtask

  // writer model: one write every 5 cycles
  task automatic do_writes(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      gw_we   = 1'b1;
      gw_addr = AW'(base + i);
      gw_data = 32'hD000_0000 + 32'(i);
      tick();
      gw_we = 1'b0;
      chk("wr_we", mem_we, 1);
      chk("wr_addr", mem_addr, base + i);
      chk("wr_data", mem_data, 32'hD000_0000 + 32'(i));
      repeat (4) tick();
    end
  endtask

  initial begin
    reset          = 1'b0;
    enable         = 1'b0;
    comp_done      = 1'b0;
    done_write_sig = 1'b0;
    gw_we          = 1'b0;
    gw_addr        = '0;
    gw_data        = '0;
    ov_req         = 1'b0;
    ov_addr        = '0;
    ov_data        = '0;
    #25;
    chk_reset("rst");
    chk("rst_gnt", ov_gnt, 0);
    tick();
    reset = 1'b1;

    repeat (100) tick();
    chk("idle_steps", step_cnt, 0);
    chk("idle_allow", comp_allow, 1);
    chk("idle_busy", busy, 0);
    chk("idle_we", mem_we, 0);
    chk("idle_frame", frame_count, 0);

    // frame 1: full frame with 64 writes
    enable = 1'b1;
    tick();
    chk("start_step", comp_step, 1);
    chk("start_busy", busy, 1);
    do_iters(1'b0);
    do_writes(64, 0);
    done_write_sig = 1'b1;
    tick();
    done_write_sig = 1'b0;
    chk("fend_allow", comp_allow, 0);
    chk("fend_frame", frame_count, 0);
    tick();
    chk("f1_allow", comp_allow, 1);
    chk("f1_frame", frame_count, 1);
    chk("f1_steps", step_cnt, 4);
    chk("f1_writes", we_cnt, 64);
    tick();
    chk("f2_step", comp_step, 1);

    // frame 2: enable dropped during 2nd iteration
    do_iters(1'b1);
    do_writes(2, 8'h40);
    done_write_sig = 1'b1;
    tick();
    done_write_sig = 1'b0;
    tick();
    chk("f2_frame", frame_count, 2);
    chk("f2_busy", busy, 0);
    chk("f2_allow", comp_allow, 1);
    repeat (20) tick();
    chk("f2_no_step", step_cnt, 8);
    chk("f2_idle", busy, 0);

    // frame 3: arbitration collision in WRITE
    enable = 1'b1;
    tick();
    chk("f3_step", comp_step, 1);
    do_iters(1'b0);
    ov_req  = 1'b1;
    ov_addr = 8'h80;
    ov_data = 32'hAAAA_0001;
    #1;
    chk("ov_gnt_free", ov_gnt, 1);
    tick();
    chk("ov_we", mem_we, 1);
    chk("ov_addr", mem_addr, 32'h80);
    chk("ov_data", mem_data, 32'hAAAA_0001);
    gw_we   = 1'b1;
    gw_addr = 8'h05;
    gw_data = 32'h0000_0005;
    #1;
    chk("ov_gnt_coll", ov_gnt, 0);
    tick();
    gw_we = 1'b0;
    chk("coll_addr", mem_addr, 32'h05);
    chk("coll_data", mem_data, 32'h5);
    #1;
    chk("ov_gnt_again", ov_gnt, 1);
    tick();
    chk("ov_late_we", mem_we, 1);
    chk("ov_late_addr", mem_addr, 32'h80);
    ov_req = 1'b0;
    tick();
    chk("hold_we", mem_we, 0);
    chk("hold_addr", mem_addr, 32'h80);
    chk("hold_data", mem_data, 32'hAAAA_0001);
    done_write_sig = 1'b1;
    tick();
    done_write_sig = 1'b0;
    tick();
    chk("f3_frame", frame_count, 3);
    tick();
    chk("f4_step", comp_step, 1);

    // frame 4: writer gated outside WRITE, then write-out stall
    gw_we   = 1'b1;
    gw_addr = 8'h33;
    do_iters(1'b0);
    gw_we = 1'b0;
    chk("gate_cnt", we_cnt, 69);
    chk("gate_we", mem_we, 0);
    repeat (19) tick();
    chk("wd_pre_terr", timeout_err, 0);
    chk("wd_pre_allow", comp_allow, 0);
    tick();
`ifdef SCHED_TIMEOUT_EN
    chk("wd_terr", timeout_err, 1);
    tick();
    chk("wd_frame", frame_count, 4);
    chk("wd_allow", comp_allow, 1);
    tick();
    chk("wd_step", comp_step, 1);
    chk("wd_sticky", timeout_err, 1);
`else
    chk("wd_terr", timeout_err, 0);
    tick();
    chk("wd_frame", frame_count, 3);
    chk("wd_allow", comp_allow, 0);
    tick();
    chk("wd_step", comp_step, 0);
    chk("wd_terr2", timeout_err, 0);
`endif
    chk("wd_busy", busy, 1);

    // asynchronous reset mid-frame
    #3;
    reset = 1'b0;
    #1;
    chk_reset("mid");
    enable = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("post_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
